// File: rtl/match_score_timer.sv
// Round countdown timer and two-player BCD score keeper for the card-match game.
// Every digit output is a registered BCD nibble ready for a seven-segment decoder.
module match_score_timer #(
  parameter int TICK_DIV   = 50000000,
  parameter int ROUND_SECS = 60
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       match_p1,
  input  logic       match_p2,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic       running,
  output logic       expired,
  output logic       second_tick
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [3:0]      ROUND_TENS = 4'(ROUND_SECS / 10);
  localparam logic [3:0]      ROUND_ONES = 4'(ROUND_SECS % 10);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_timeTens;
  logic [3:0]    r_timeOnes;
  logic [7:0]    r_p1Score;
  logic [7:0]    r_p2Score;
  logic          r_running;
  logic          r_expired;
  logic          r_tick;

  logic [7:0]    w_timeDec;
  logic          w_wrap;
  logic          w_lastSec;

  // Saturating two-digit BCD increment; 99 is sticky.
  function automatic logic [7:0] scoreInc(input logic [7:0] s);
    if (s == 8'h99)
      return s;
    else if (s[3:0] == 4'd9)
      return {s[7:4] + 4'd1, 4'd0};
    else
      return {s[7:4], s[3:0] + 4'd1};
  endfunction

  always_comb begin
    w_timeDec = {r_timeTens, r_timeOnes};
    if (r_timeOnes != 4'd0)
      w_timeDec = {r_timeTens, r_timeOnes - 4'd1};
    else
      w_timeDec = {r_timeTens - 4'd1, 4'd9};
  end

  assign w_wrap    = (r_presc == PRESC_MAX);
  assign w_lastSec = (r_timeTens == 4'd0) && (r_timeOnes == 4'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_presc    <= '0;
      r_timeTens <= 4'd0;
      r_timeOnes <= 4'd0;
      r_p1Score  <= 8'h00;
      r_p2Score  <= 8'h00;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // A start wins over any coincident match pulse, so scores always clear.
          if (start) begin
            r_state    <= RUN;
            r_presc    <= '0;
            r_timeTens <= ROUND_TENS;
            r_timeOnes <= ROUND_ONES;
            r_p1Score  <= 8'h00;
            r_p2Score  <= 8'h00;
            r_running  <= 1'b1;
            r_expired  <= 1'b0;
          end
        end
        RUN: begin
          if (!pause) begin
            if (match_p1) r_p1Score <= scoreInc(r_p1Score);
            if (match_p2) r_p2Score <= scoreInc(r_p2Score);
            if (w_wrap) begin
              r_presc                  <= '0;
              r_tick                   <= 1'b1;
              {r_timeTens, r_timeOnes} <= w_timeDec;
              if (w_lastSec) begin
                r_state   <= DONE;
                r_running <= 1'b0;
                r_expired <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign time_tens   = r_timeTens;
  assign time_ones   = r_timeOnes;
  assign p1_tens     = r_p1Score[7:4];
  assign p1_ones     = r_p1Score[3:0];
  assign p2_tens     = r_p2Score[7:4];
  assign p2_ones     = r_p2Score[3:0];
  assign running     = r_running;
  assign expired     = r_expired;
  assign second_tick = r_tick;

endmodule

// File: tb/tb_match_score_timer.sv
// Scoreboard bench for match_score_timer: the driver queues expected outputs per edge,
// a monitor pops and compares them after each edge and also checks every second_tick.
module tb_match_score_timer;

  typedef struct {
    int          cyc;
    int          inst;
    string       name;
    logic [26:0] expv;
    logic [26:0] mask;
  } rec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0, pause = 1'b0, match_p1 = 1'b0, match_p2 = 1'b0;
  logic [3:0] time_tens, time_ones, p1_tens, p1_ones, p2_tens, p2_ones;
  logic running, expired, second_tick;

  logic startB = 1'b0, pauseB = 1'b0, m1B = 1'b0, m2B = 1'b0;
  logic [3:0] ttB, toB, p1tB, p1oB, p2tB, p2oB;
  logic runningB, expiredB, tickB;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  rec_t q[$];
  int tickQ[$];
  rec_t monRec;
  int monT;

  match_score_timer #(.TICK_DIV(4), .ROUND_SECS(12)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause),
    .match_p1(match_p1), .match_p2(match_p2),
    .time_tens(time_tens), .time_ones(time_ones),
    .p1_tens(p1_tens), .p1_ones(p1_ones), .p2_tens(p2_tens), .p2_ones(p2_ones),
    .running(running), .expired(expired), .second_tick(second_tick)
  );

  // Longer round so a single round fits enough pulses to reach score saturation.
  match_score_timer #(.TICK_DIV(8), .ROUND_SECS(20)) dutB (
    .clock(clock), .reset_n(reset_n), .start(startB), .pause(pauseB),
    .match_p1(m1B), .match_p2(m2B),
    .time_tens(ttB), .time_ones(toB),
    .p1_tens(p1tB), .p1_ones(p1oB), .p2_tens(p2tB), .p2_ones(p2oB),
    .running(runningB), .expired(expiredB), .second_tick(tickB)
  );

  always #5 clock = ~clock;

  function automatic logic [26:0] vec(input int t, input int a, input int b,
                                      input bit r, input bit e, input bit k);
    return {4'(t / 10), 4'(t % 10), 4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10), r, e, k};
  endfunction

  function automatic logic [26:0] actA();
    return {time_tens, time_ones, p1_tens, p1_ones, p2_tens, p2_ones, running, expired, second_tick};
  endfunction

  function automatic logic [26:0] actB();
    return {ttB, toB, p1tB, p1oB, p2tB, p2oB, runningB, expiredB, tickB};
  endfunction

  task automatic checkOutput(input string name, input logic [26:0] act,
                             input logic [26:0] expv, input logic [26:0] mask);
    checks++;
    if ((act & mask) !== (expv & mask)) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h (mask %h)",
               name, cyc, act & mask, expv & mask, mask);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit a, input bit b);
    @(negedge clock);
    start = s; pause = p; match_p1 = a; match_p2 = b;
    startB = 1'b0; m1B = 1'b0;
  endtask

  task automatic applyStimulusB(input bit s, input bit a);
    @(negedge clock);
    startB = s; m1B = a;
    start = 1'b0; pause = 1'b0; match_p1 = 1'b0; match_p2 = 1'b0;
  endtask

  task automatic expectMain(input string name, input int t, input int a, input int b,
                            input bit r, input bit e, input bit k);
    rec_t rec;
    rec.cyc  = cyc + 1;
    rec.inst = 0;
    rec.name = name;
    rec.expv = vec(t, a, b, r, e, k);
    rec.mask = '1;
    q.push_back(rec);
    if (k) tickQ.push_back(t);
  endtask

  task automatic expectB(input string name, input int a);
    rec_t rec;
    rec.cyc  = cyc + 1;
    rec.inst = 1;
    rec.name = name;
    rec.expv = vec(0, a, 0, 1'b1, 1'b0, 1'b0);
    rec.mask = (27'hFF << 11) | 27'h4;
    q.push_back(rec);
  endtask

  // Monitor: compares queued expectations for this edge and every timer tick.
  always @(posedge clock) begin
    cyc++;
    #2;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      monRec = q.pop_front();
      checkOutput(monRec.name, (monRec.inst == 0) ? actA() : actB(), monRec.expv, monRec.mask);
    end
    if (second_tick) begin
      if (tickQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedTick at cycle %0d: got time %h%h expected no tick",
                 cyc, time_tens, time_ones);
      end else begin
        monT = tickQ.pop_front();
        checkOutput("tickTime", actA(), vec(monT, 0, 0, 0, 0, 0), 27'hFF << 19);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset_n = 1'b0;
    #10 checkOutput("resetState", actA(), 27'd0, '1);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(1, 0, 1, 1); expectMain("startWithMatch", 12, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1); expectMain("dualMatch", 12, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); expectMain("tickWait1", 12, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); expectMain("tickWait2", 12, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); expectMain("firstTick", 11, 1, 1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0); expectMain("startInRun", 11, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); expectMain("prePause", 11, 1, 1, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, (i % 2) == 0, (i % 3) == 0);
      expectMain("paused", 11, 1, 1, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0); expectMain("resumeCount", 11, 1, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); expectMain("resumeTick", 10, 1, 1, 1, 0, 1);

    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 0, 1, 0);
      expectMain("p1CarryBorrow", (k >= 8) ? 8 : ((k >= 4) ? 9 : 10), 1 + k, 1, 1, 0, (k % 4) == 0);
    end

    for (int j = 10; j <= 40; j++) begin
      applyStimulus(0, 0, j == 40, j == 40);
      expectMain("countdown", 8 - (j - 8) / 4, (j == 40) ? 11 : 10, (j == 40) ? 2 : 1,
                 j < 40, j == 40, (j % 4) == 0);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, i == 2, i == 0, i == 1);
      expectMain("doneHold", 0, 11, 2, 0, 1, 0);
    end

    applyStimulusB(1, 0); expectB("bStart", 0);
    for (int k = 1; k <= 101; k++) begin
      applyStimulusB(0, 1);
      expectB("p1Saturate", (k > 99) ? 99 : k);
    end

    applyStimulus(1, 0, 0, 0); expectMain("restartFromDone", 12, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0); expectMain("restartMatch", 12, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); expectMain("restartHold", 12, 1, 0, 1, 0, 0);

    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 checkOutput("asyncReset", actA(), 27'd0, '1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 1);
      expectMain("idleAfterReset", 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0); expectMain("startAfterReset", 12, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0); expectMain("runAfterReset", 12, 0, 0, 1, 0, 0);
    repeat (3) @(negedge clock);

    checks++;
    if (q.size() != 0 || tickQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pendingExpectations: got %0d records and %0d ticks left, expected 0 and 0",
               q.size(), tickQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
